// File: rtl/if_stage_mo.sv
// if_stage_mo: multi-outstanding instruction fetch stage with an in-order instruction buffer
module if_stage_mo #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ds_allowin,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         ex_flush,
  input  logic [31:0]  ex_pc,
  output logic         fs_to_ds_valid,
  output logic [102:0] fs_to_ds_bus,
  output logic         inst_sram_req,
  output logic         inst_sram_wr,
  output logic [1:0]   inst_sram_size,
  output logic [31:0]  inst_sram_addr,
  output logic [3:0]   inst_sram_wstrb,
  output logic [31:0]  inst_sram_wdata,
  input  logic         inst_sram_addrok,
  input  logic         inst_sram_dataok,
  input  logic [31:0]  inst_sram_rdata
);
  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic                  halted_q, halted_d;
  logic [IW-1:0]         inflight_q, inflight_d, dcnt_q, dcnt_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           pc_q [IBUF_DEPTH];
  logic [31:0]           pc_d [IBUF_DEPTH];
  logic [31:0]           inst_q [IBUF_DEPTH];
  logic [31:0]           inst_d [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] ex_q, ex_d, filled_q, filled_d;
  logic                  flush_now, has_room, issue, misalign, alloc, fill, drop, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;
  assign inst_sram_addr  = fetch_pc_q;
  assign flush_now = redirect_valid | ex_flush;
  assign has_room  = count_q < CW'(IBUF_DEPTH);
  assign inst_sram_req = !reset && !halted_q && !flush_now && fetch_pc_q[1:0] == 2'b00
                         && inflight_q < IW'(MAX_OUTSTANDING) && has_room;
  assign issue    = inst_sram_req && inst_sram_addrok;
  // a misaligned pc becomes a ready-made exception entry and stops fetching until a flush
  assign misalign = !reset && !halted_q && !flush_now && fetch_pc_q[1:0] != 2'b00 && has_room;
  assign alloc    = issue || misalign;
  assign drop     = inst_sram_dataok && dcnt_q != '0;
  assign fill     = inst_sram_dataok && dcnt_q == '0;
  assign fs_to_ds_valid = count_q != '0 && filled_q[head_q];
  assign pop      = fs_to_ds_valid && ds_allowin && !flush_now;
  assign fs_to_ds_bus = {ex_q[head_q], ex_q[head_q] ? 5'h04 : 5'h00, 1'b0, pc_q[head_q],
                         inst_q[head_q], pc_q[head_q]};
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fptr_d     = fptr_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ex_d       = ex_q;
    filled_d   = filled_q;
    count_d    = count_q + CW'(alloc) - CW'(pop);
    inflight_d = inflight_q + IW'(issue) - IW'(inst_sram_dataok);
    dcnt_d     = drop ? dcnt_q - 1'b1 : dcnt_q;
    if (alloc) begin
      pc_d[tail_q]     = fetch_pc_q;
      inst_d[tail_q]   = 32'd0;
      ex_d[tail_q]     = misalign;
      filled_d[tail_q] = misalign;
      tail_d           = inc(tail_q);
    end
    if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
    if (misalign) halted_d = 1'b1;
    // responses are in order, so the fill pointer always names the oldest unfilled entry
    if (fill) begin
      inst_d[fptr_q]   = inst_sram_rdata;
      ex_d[fptr_q]     = 1'b0;
      filled_d[fptr_q] = 1'b1;
      fptr_d           = inc(fptr_q);
    end
    if (pop) head_d = inc(head_q);
    if (flush_now) begin
      fetch_pc_d = ex_flush ? ex_pc : redirect_pc;
      halted_d   = 1'b0;
      count_d    = '0;
      head_d     = tail_q;
      fptr_d     = tail_q;
      filled_d   = '0;
      dcnt_d     = inflight_q - IW'(inst_sram_dataok);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
      inflight_q <= '0;
      dcnt_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fptr_q     <= '0;
      count_q    <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
      inflight_q <= inflight_d;
      dcnt_q     <= dcnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fptr_q     <= fptr_d;
      count_q    <= count_d;
      filled_q   <= filled_d;
    end
  end
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
    ex_q   <= ex_d;
  end
  assert property (@(posedge clk) disable iff (reset) !(inst_sram_dataok && inflight_q == '0));
endmodule

// File: tb/tb_if_stage_mo.sv
// tb_if_stage_mo: directed tests of if_stage_mo against an in-order latency memory model
module tb_if_stage_mo;
  logic         clk = 1'b0;
  logic         reset;
  logic         ds_allowin;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         ex_flush;
  logic [31:0]  ex_pc;
  logic         fs_to_ds_valid;
  logic [102:0] fs_to_ds_bus;
  logic         inst_sram_req;
  logic         inst_sram_wr;
  logic [1:0]   inst_sram_size;
  logic [31:0]  inst_sram_addr;
  logic [3:0]   inst_sram_wstrb;
  logic [31:0]  inst_sram_wdata;
  logic         inst_sram_addrok;
  logic         inst_sram_dataok;
  logic [31:0]  inst_sram_rdata;
  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 1;
  logic mem_addrok = 1'b1;
  int n_acc = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic        got_ex[$];
  logic [4:0]  got_code[$];
  logic [31:0] got_bad[$];

  if_stage_mo dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ex_flush(ex_flush), .ex_pc(ex_pc),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addrok(inst_sram_addrok), .inst_sram_dataok(inst_sram_dataok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // memory: returns ~addr, strictly in order, mem_lat cycles after acceptance
  initial begin
    logic acc, dv;
    logic [31:0] aaddr;
    int cyc;
    logic [31:0] q_addr[$];
    int q_due[$];
    cyc = 0;
    inst_sram_addrok = 1'b0;
    inst_sram_dataok = 1'b0;
    inst_sram_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      acc   = inst_sram_req && inst_sram_addrok;
      dv    = inst_sram_dataok;
      aaddr = inst_sram_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        q_addr.delete();
        q_due.delete();
      end else begin
        if (dv && q_addr.size() > 0) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (acc) begin
          q_addr.push_back(aaddr);
          q_due.push_back(cyc + mem_lat - 1);
          n_acc++;
        end
      end
      inst_sram_addrok = mem_addrok;
      inst_sram_dataok = q_addr.size() > 0 && q_due[0] <= cyc;
      inst_sram_rdata  = q_addr.size() > 0 ? ~q_addr[0] : 32'd0;
    end
  end

  // ID side: log every instruction actually taken
  initial forever begin
    @(negedge clk);
    if (!reset && fs_to_ds_valid === 1'b1 && ds_allowin && !redirect_valid && !ex_flush) begin
      got_pc.push_back(fs_to_ds_bus[31:0]);
      got_inst.push_back(fs_to_ds_bus[63:32]);
      got_bad.push_back(fs_to_ds_bus[95:64]);
      got_code.push_back(fs_to_ds_bus[101:97]);
      got_ex.push_back(fs_to_ds_bus[102]);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat, input logic allow);
    @(posedge clk); #2;
    reset = 1'b1;
    redirect_valid = 1'b0;
    ex_flush = 1'b0;
    ds_allowin = allow;
    mem_lat = lat;
    mem_addrok = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    adv(2);
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", inst_sram_req); end
    n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", fs_to_ds_valid); end
    n_cmp++; if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb} !== 7'b0_10_0000) begin
      n_bad++; $display("FAIL rst_const: got %b want 0100000", {inst_sram_wr, inst_sram_size, inst_sram_wstrb}); end
    n_cmp++; if (inst_sram_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", inst_sram_wdata); end
  endtask

  task automatic test_first_fetch();
    int b;
    logic [31:0] e;
    do_reset(1, 1'b1);
    b = got_pc.size();
    n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00000) begin
      n_bad++; $display("FAIL ff_first_req: got %b/%h want 1/bfc00000", inst_sram_req, inst_sram_addr); end
    adv(1);
    n_cmp++; if (inst_sram_addr !== 32'hbfc00004 || fs_to_ds_valid !== 1'b0) begin
      n_bad++; $display("FAIL ff_second: got %h/%b want bfc00004/0", inst_sram_addr, fs_to_ds_valid); end
    adv(1);
    n_cmp++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:0] !== {~32'hbfc00000, 32'hbfc00000}) begin
      n_bad++; $display("FAIL ff_deliver: got %b/%h want 1/%h", fs_to_ds_valid, fs_to_ds_bus[63:0], {~32'hbfc00000, 32'hbfc00000}); end
    adv(6);
    for (int i = 0; i < 4; i++) begin
      e = 32'hbfc00000 + 32'(4 * i);
      n_cmp++; if (got_pc[b+i] !== e || got_inst[b+i] !== ~e) begin
        n_bad++; $display("FAIL ff_seq%0d: got %h/%h want %h/%h", i, got_pc[b+i], got_inst[b+i], e, ~e); end
    end
  endtask

  task automatic test_outstanding();
    int b, n0;
    logic [31:0] e;
    do_reset(5, 1'b1);
    b = got_pc.size();
    n0 = n_acc;
    adv(5);
    n_cmp++; if (n_acc - n0 !== 2) begin n_bad++; $display("FAIL mo_accepts: got %0d want 2", n_acc - n0); end
    n_cmp++; if (inst_sram_req !== 1'b0 || inst_sram_dataok !== 1'b1) begin
      n_bad++; $display("FAIL mo_hold: got req %b dataok %b want 0/1", inst_sram_req, inst_sram_dataok); end
    adv(1);
    n_cmp++; if (inst_sram_req !== 1'b1) begin n_bad++; $display("FAIL mo_resume: got %b want 1", inst_sram_req); end
    adv(30);
    for (int i = 0; i < 4; i++) begin
      e = 32'hbfc00000 + 32'(4 * i);
      n_cmp++; if (got_pc[b+i] !== e || got_inst[b+i] !== ~e) begin
        n_bad++; $display("FAIL mo_seq%0d: got %h/%h want %h/%h", i, got_pc[b+i], got_inst[b+i], e, ~e); end
    end
  endtask

  task automatic test_full_buffer();
    int b, n0;
    logic [31:0] e;
    do_reset(1, 1'b0);
    n0 = n_acc;
    adv(10);
    n_cmp++; if (n_acc - n0 !== 4) begin n_bad++; $display("FAIL fb_accepts: got %0d want 4", n_acc - n0); end
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_bad++; $display("FAIL fb_req: got %b want 0", inst_sram_req); end
    n_cmp++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[31:0] !== 32'hbfc00000) begin
      n_bad++; $display("FAIL fb_head: got %b/%h want 1/bfc00000", fs_to_ds_valid, fs_to_ds_bus[31:0]); end
    @(posedge clk); #2;
    ds_allowin = 1'b1;
    b = got_pc.size();
    adv(8);
    for (int i = 0; i < 5; i++) begin
      e = 32'hbfc00000 + 32'(4 * i);
      n_cmp++; if (got_pc[b+i] !== e || got_inst[b+i] !== ~e) begin
        n_bad++; $display("FAIL fb_seq%0d: got %h/%h want %h/%h", i, got_pc[b+i], got_inst[b+i], e, ~e); end
    end
  endtask

  task automatic test_redirect();
    int b;
    do_reset(2, 1'b0);
    @(posedge clk); #2;
    mem_lat = 6;
    @(negedge clk);
    adv(2);
    n_cmp++; if (fs_to_ds_valid !== 1'b1) begin n_bad++; $display("FAIL rd_buffered: got %b want 1", fs_to_ds_valid); end
    @(posedge clk); #2;
    redirect_valid = 1'b1;
    redirect_pc = 32'hbfc00100;
    ds_allowin = 1'b1;
    @(negedge clk);
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_bad++; $display("FAIL rd_req_flush: got %b want 0", inst_sram_req); end
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    mem_lat = 1;
    b = got_pc.size();
    @(negedge clk);
    n_cmp++; if (fs_to_ds_valid !== 1'b0 || inst_sram_addr !== 32'hbfc00100) begin
      n_bad++; $display("FAIL rd_cleared: got %b/%h want 0/bfc00100", fs_to_ds_valid, inst_sram_addr); end
    adv(20);
    n_cmp++; if (got_pc[b] !== 32'hbfc00100 || got_inst[b] !== ~32'hbfc00100) begin
      n_bad++; $display("FAIL rd_first: got %h/%h want bfc00100/%h", got_pc[b], got_inst[b], ~32'hbfc00100); end
    n_cmp++; if (got_pc[b+1] !== 32'hbfc00104 || got_inst[b+1] !== ~32'hbfc00104) begin
      n_bad++; $display("FAIL rd_second: got %h/%h want bfc00104/%h", got_pc[b+1], got_inst[b+1], ~32'hbfc00104); end
  endtask

  task automatic test_ex_priority();
    int b;
    do_reset(2, 1'b1);
    adv(1);
    @(posedge clk); #2;
    ex_flush = 1'b1;
    ex_pc = 32'hbfc00380;
    redirect_valid = 1'b1;
    redirect_pc = 32'hbfc00100;
    b = got_pc.size();
    @(negedge clk);
    n_cmp++; if (inst_sram_dataok !== 1'b1 || inst_sram_req !== 1'b0) begin
      n_bad++; $display("FAIL ex_setup: got dataok %b req %b want 1/0", inst_sram_dataok, inst_sram_req); end
    @(posedge clk); #2;
    ex_flush = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00380) begin
      n_bad++; $display("FAIL ex_restart: got %b/%h want 1/bfc00380", inst_sram_req, inst_sram_addr); end
    adv(15);
    n_cmp++; if (got_pc[b] !== 32'hbfc00380 || got_inst[b] !== ~32'hbfc00380) begin
      n_bad++; $display("FAIL ex_first: got %h/%h want bfc00380/%h", got_pc[b], got_inst[b], ~32'hbfc00380); end
    n_cmp++; if (got_pc[b+1] !== 32'hbfc00384 || got_inst[b+1] !== ~32'hbfc00384) begin
      n_bad++; $display("FAIL ex_second: got %h/%h want bfc00384/%h", got_pc[b+1], got_inst[b+1], ~32'hbfc00384); end
  endtask

  task automatic test_misaligned();
    int b, n0;
    do_reset(1, 1'b1);
    adv(3);
    @(posedge clk); #2;
    redirect_valid = 1'b1;
    redirect_pc = 32'hbfc00102;
    b = got_pc.size();
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    n0 = n_acc;
    @(negedge clk);
    n_cmp++; if (inst_sram_req !== 1'b0 || inst_sram_addr !== 32'hbfc00102) begin
      n_bad++; $display("FAIL ma_noreq: got %b/%h want 0/bfc00102", inst_sram_req, inst_sram_addr); end
    adv(10);
    n_cmp++; if (n_acc !== n0 || inst_sram_req !== 1'b0) begin
      n_bad++; $display("FAIL ma_halted: got accepts %0d req %b want 0/0", n_acc - n0, inst_sram_req); end
    n_cmp++; if (got_pc.size() !== b + 1) begin n_bad++; $display("FAIL ma_count: got %0d want 1", got_pc.size() - b); end
    n_cmp++; if ({got_ex[b], got_code[b], got_bad[b], got_pc[b]} !== {1'b1, 5'h04, 32'hbfc00102, 32'hbfc00102}) begin
      n_bad++; $display("FAIL ma_entry: got ex %b code %h bad %h pc %h want 1/04/bfc00102/bfc00102",
                        got_ex[b], got_code[b], got_bad[b], got_pc[b]); end
    @(posedge clk); #2;
    redirect_valid = 1'b1;
    redirect_pc = 32'hbfc00200;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hbfc00200) begin
      n_bad++; $display("FAIL ma_unhalt: got %b/%h want 1/bfc00200", inst_sram_req, inst_sram_addr); end
  endtask

  initial begin
    reset = 1'b1;
    ds_allowin = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    ex_flush = 1'b0;
    ex_pc = 32'd0;
    test_reset();
    test_first_fetch();
    test_outstanding();
    test_full_buffer();
    test_redirect();
    test_ex_priority();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
